pipe_fetch: RTL and testbench
=============================

// Module: pipe_fetch
// PURPOSE
//  Instruction-fetch (IF) stage plus IF/ID pipeline register; feeds the decode stage its dpc4/inst.
//  Holds the PC and selects next PC from pcsource/bpc/rpc/jpc as returned by decode.
//  Talks to instruction memory over a req/ready handshake with wait states.
//  Obeys the decode-stage stall (wpcir). Default semantics: one branch delay slot.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  NOP_INST  32'h0000_0000  encoding inserted as a bubble (sll $0,$0,0)
// PORTS
//  clock       in   1   single clock; all state on rising edge
//  resetn      in   1   asynchronous, active-low reset
//  pcsource    in   2   from decode: 00 pc+4, 01 bpc, 10 rpc, 11 jpc
//  bpc         in   32  branch target from decode
//  rpc         in   32  jr target (forwarded rs) from decode
//  jpc         in   32  jump target from decode
//  wpcir       in   1   1 = PC and IF/ID may advance; 0 = stall both
//  imem_req    out  1   fetch request, level
//  imem_addr   out  32  fetch address (= pc)
//  imem_ready  in   1   request accepted and data valid this cycle
//  imem_rdata  in   32  instruction word, valid with imem_ready
//  pc          out  32  current fetch PC
//  dpc4        out  32  IF/ID: PC+4 of instruction in decode
//  inst        out  32  IF/ID: instruction in decode
//  dvalid      out  1   IF/ID: 1 = real instruction, 0 = bubble
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, imem_req=0, inst=NOP_INST, dpc4=RESET_PC+4, dvalid=0,
//   skid buffer and redirect register empty. imem_req rises first edge after release.
//  Handshake: transfer = imem_req & imem_ready. imem_addr stable while imem_req=1 and not ready.
//   Request is never withdrawn before acceptance (except by reset).
//  Fetch-done F = transfer | buf_valid; word W = buf_valid ? buf : imem_rdata.
//  F & wpcir: IF/ID <= {pc+4, W, 1}; pc <= npc; buffer cleared; req for new pc next cycle.
//  F & !wpcir: transfer word captured in 1-entry skid buffer; req=0 until buffer drains; pc, IF/ID held.
//  !F & wpcir: IF/ID <= bubble {dpc4 held, NOP_INST, 0}; pc held, req stays high.
//  !F & !wpcir: everything held.
//  npc: redirect register if valid (then clear), else pcsource mux; 32-bit arithmetic, pc+4 wraps mod 2^32.
//  Redirect capture: pcsource!=00 & wpcir=1 while !F -> redir_pc<=target, redir_valid<=1
//   (decoded branch leaves ID before its delay slot is fetched). Simultaneous F: use target directly, no capture.
//  Latency: 1 cycle from accepted fetch to inst at decode when wpcir=1; zero-wait memory gives 1 inst/cycle.
// CONFIGURATION
//  PIPE_FETCH_KILL_EN undefined: delay slot executes; redirect takes effect on fetch after the slot.
//  PIPE_FETCH_KILL_EN defined: no delay slot. pcsource!=00 & wpcir=1 -> word loaded into IF/ID
//   becomes bubble (NOP_INST, dvalid=0). pc <= target at once. A request already outstanding
//   completes per handshake; its data is discarded (kill flag), then target is fetched.
// STRUCTURE
//  Shared package cpu_pkg: PCSRC_SEQ/BR/JR/J codes (2-bit), NOP_INST, RESET_PC, 32-bit word width.
//  Sub-module fetch_skid (1-entry buffer: load, drain, valid, data); rest (PC, FSM REQ/WAIT/HOLD, IF/ID reg) inline.
// TESTING
//  1 reset, ready tied 1, pcsource=00, wpcir=1 -> imem_addr 0,4,8,...; inst = mem word 1 cycle later, dvalid=1.
//  2 ready=0 for 3 cycles at addr 0x10 -> addr stays 0x10, 3 bubbles (dvalid=0), then inst=mem[0x10].
//  3 wpcir=0 for 2 cycles with ready=1 -> pc, dpc4, inst frozen; word buffered; req=0; no fetch lost/repeated on release.
//  4 branch in ID, pcsource=01, bpc=0x100, delay slot at 0x24 waits 2 cycles -> 0x24 executes, next addr 0x100.
//  5 KILL_EN: pcsource=11, jpc=0x200 -> slot word enters IF/ID as NOP, dvalid=0; next accepted addr 0x200.
//  6 resetn low mid-wait (req high, ready=0) -> req=0, pc=RESET_PC, dvalid=0 immediately, before next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word type, next-PC source codes, bubble encoding, reset PC,
// fetch FSM states and the IF/ID register layout.
package cpu_pkg;
  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_JR  = 2'b10,
    PCSRC_J   = 2'b11
  } pcsrc_e;

  localparam word_t NOP_INST = 32'h0000_0000;
  localparam word_t RESET_PC = 32'h0000_0000;

  // IDLE only exists for the cycle after reset so req rises one edge after release.
  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT, F_HOLD} fstate_e;

  typedef struct packed {
    word_t dpc4;
    word_t inst;
    logic  dvalid;
  } ifid_t;

  function automatic word_t pc_plus4(input word_t p);
    return p + 32'd4;
  endfunction
endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched word while decode is stalled.
module fetch_skid
  import cpu_pkg::*;
(
  input  logic  clock,
  input  logic  resetn,
  input  logic  load,
  input  logic  drain,
  input  word_t din,
  output logic  valid,
  output word_t dout
);
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/pipe_fetch.sv
// IF stage + IF/ID register. Default: one branch delay slot. Define PIPE_FETCH_KILL_EN
// to drop the delay slot (the word behind a taken redirect is squashed to a bubble).
module pipe_fetch #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        wpcir,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        dvalid
);
  import cpu_pkg::*;

  fstate_e state_q, state_d;
  ifid_t   ifid_q;
  word_t   buf_data, w, target, npc, redir_pc;
  logic    buf_valid, transfer, f, redirect, redir_valid, squash;

  assign imem_req  = (state_q == F_REQ) || (state_q == F_WAIT);
  assign imem_addr = pc;
  assign transfer  = imem_req & imem_ready;
  assign f         = transfer | buf_valid;
  assign w         = buf_valid ? buf_data : imem_rdata;
  assign redirect  = (pcsource != PCSRC_SEQ) && wpcir;

  always_comb begin
    target = pc_plus4(pc);
    case (pcsource)
      PCSRC_BR: target = bpc;
      PCSRC_JR: target = rpc;
      PCSRC_J:  target = jpc;
      default:  target = pc_plus4(pc);
    endcase
  end

  // A redirect decoded while the slot fetch was still pending takes priority.
  assign npc = redir_valid ? redir_pc : target;

  fetch_skid u_skid (
    .clock  (clock),
    .resetn (resetn),
    .load   (transfer & ~wpcir),
    .drain  (f & wpcir),
    .din    (imem_rdata),
    .valid  (buf_valid),
    .dout   (buf_data)
  );

`ifdef PIPE_FETCH_KILL_EN
  logic kill_q;

  // The fetch in flight when a redirect arrives cannot be retargeted; drop its data instead.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)          kill_q <= 1'b0;
    else if (f && wpcir)  kill_q <= 1'b0;
    else if (redirect)    kill_q <= 1'b1;
  end

  assign squash = kill_q | redirect;
`else
  assign squash = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      redir_valid <= 1'b0;
      redir_pc    <= '0;
    end else if (f && wpcir) begin
      redir_valid <= 1'b0;
    end else if (!f && redirect) begin
      redir_valid <= 1'b1;
      redir_pc    <= target;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) pc <= RESET_PC;
    else if (f && wpcir) pc <= npc;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ifid_q <= '{dpc4: RESET_PC + 32'd4, inst: NOP_INST, dvalid: 1'b0};
    end else if (wpcir) begin
      if (f && !squash) ifid_q <= '{dpc4: pc_plus4(pc), inst: w, dvalid: 1'b1};
      else              ifid_q <= '{dpc4: ifid_q.dpc4, inst: NOP_INST, dvalid: 1'b0};
    end
  end

  assign dpc4   = ifid_q.dpc4;
  assign inst   = ifid_q.inst;
  assign dvalid = ifid_q.dvalid;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= F_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      F_IDLE: state_d = F_REQ;
      F_REQ, F_WAIT: begin
        if (transfer) state_d = wpcir ? F_REQ : F_HOLD;
        else          state_d = F_WAIT;
      end
      F_HOLD: if (wpcir) state_d = F_REQ;
      default: state_d = F_IDLE;
    endcase
  end
endmodule

// File: tb/tb_pipe_fetch.sv
// Directed bench for pipe_fetch with a combinational instruction memory model.
module tb_pipe_fetch;
`ifdef PIPE_FETCH_KILL_EN
  localparam bit KILL = 1'b1;
`else
  localparam bit KILL = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        resetn;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic        wpcir;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc, dpc4, inst;
  logic        dvalid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  assign imem_rdata = memw(imem_addr);

  pipe_fetch dut (
    .clock      (clock),
    .resetn     (resetn),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .wpcir      (wpcir),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .dpc4       (dpc4),
    .inst       (inst),
    .dvalid     (dvalid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Check the IF/ID contents and the current fetch address.
  task automatic chk_ifid(input string tag, input logic [31:0] e_inst, input logic e_v,
                          input logic [31:0] e_dpc4, input logic [31:0] e_addr);
    chk({tag, ".inst"},   inst, e_inst);
    chk({tag, ".dvalid"}, {31'd0, dvalid}, {31'd0, e_v});
    chk({tag, ".dpc4"},   dpc4, e_dpc4);
    chk({tag, ".addr"},   imem_addr, e_addr);
  endtask

  task automatic reset_release();
    @(negedge clock);
    resetn = 1'b1;
    tick();
    chk("rel.req", {31'd0, imem_req}, 32'd1);
    chk("rel.addr", imem_addr, 32'h0);
    chk("rel.dvalid", {31'd0, dvalid}, 32'd0);
  endtask

  initial begin
    resetn = 1'b0; pcsource = 2'b00; bpc = '0; rpc = '0; jpc = '0;
    wpcir = 1'b1; imem_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst.req", {31'd0, imem_req}, 32'd0);
    chk("rst.pc", pc, 32'h0);
    chk("rst.inst", inst, NOP);
    chk("rst.dpc4", dpc4, 32'h4);
    chk("rst.dvalid", {31'd0, dvalid}, 32'd0);
    reset_release();

    // 1: zero-wait sequential fetch
    tick(); chk_ifid("seq0", memw(32'h0), 1'b1, 32'h4,  32'h4);
    tick(); chk_ifid("seq1", memw(32'h4), 1'b1, 32'h8,  32'h8);
    tick(); chk_ifid("seq2", memw(32'h8), 1'b1, 32'hC,  32'hC);
    tick(); chk_ifid("seq3", memw(32'hC), 1'b1, 32'h10, 32'h10);

    // 2: three wait states at 0x10
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_ifid("wait", NOP, 1'b0, 32'h10, 32'h10);
      chk("wait.req", {31'd0, imem_req}, 32'd1);
    end
    imem_ready = 1'b1;
    tick(); chk_ifid("wait.done", memw(32'h10), 1'b1, 32'h14, 32'h14);

    // 3: decode stall with ready memory; word parked in skid buffer
    wpcir = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(); chk_ifid("stall", memw(32'h10), 1'b1, 32'h14, 32'h14);
      chk("stall.req", {31'd0, imem_req}, 32'd0);
      chk("stall.pc", pc, 32'h14);
    end
    wpcir = 1'b1;
    tick(); chk_ifid("stall.rel", memw(32'h14), 1'b1, 32'h18, 32'h18);
    chk("stall.relreq", {31'd0, imem_req}, 32'd1);
    tick(); chk_ifid("stall.nx0", memw(32'h18), 1'b1, 32'h1C, 32'h1C);
    tick(); chk_ifid("stall.nx1", memw(32'h1C), 1'b1, 32'h20, 32'h20);
    tick(); chk_ifid("br.inid", memw(32'h20), 1'b1, 32'h24, 32'h24);

    // 4: branch in ID while its delay slot at 0x24 waits two cycles
    pcsource = 2'b01; bpc = 32'h100; imem_ready = 1'b0;
    tick(); chk_ifid("br.w0", NOP, 1'b0, 32'h24, 32'h24);
    pcsource = 2'b00; bpc = 32'h0;
    tick(); chk_ifid("br.w1", NOP, 1'b0, 32'h24, 32'h24);
    imem_ready = 1'b1;
    tick();
    if (KILL) chk_ifid("br.slot", NOP, 1'b0, 32'h24, 32'h100);
    else      chk_ifid("br.slot", memw(32'h24), 1'b1, 32'h28, 32'h100);
    tick(); chk_ifid("br.tgt", memw(32'h100), 1'b1, 32'h104, 32'h104);

    // 6: async reset in the middle of a wait state
    imem_ready = 1'b0;
    tick(); chk("mid.req", {31'd0, imem_req}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mid.req0", {31'd0, imem_req}, 32'd0);
    chk("mid.pc", pc, 32'h0);
    chk("mid.dvalid", {31'd0, dvalid}, 32'd0);
    chk("mid.inst", inst, NOP);
    imem_ready = 1'b1;
    reset_release();
    tick(); chk_ifid("r2.s0", memw(32'h0), 1'b1, 32'h4, 32'h4);
    tick(); chk_ifid("r2.s1", memw(32'h4), 1'b1, 32'h8, 32'h8);

    // 5 / redirect with fetch done in the same cycle: jump to 0x200
    pcsource = 2'b11; jpc = 32'h200;
    tick();
    if (KILL) chk_ifid("j.slot", NOP, 1'b0, 32'h8, 32'h200);
    else      chk_ifid("j.slot", memw(32'h8), 1'b1, 32'hC, 32'h200);
    pcsource = 2'b00;
    tick(); chk_ifid("j.tgt", memw(32'h200), 1'b1, 32'h204, 32'h204);

    // jr to the top word: pc+4 wraps to 0
    pcsource = 2'b10; rpc = 32'hFFFF_FFFC;
    tick();
    if (KILL) chk_ifid("jr.slot", NOP, 1'b0, 32'h204, 32'hFFFF_FFFC);
    else      chk_ifid("jr.slot", memw(32'h204), 1'b1, 32'h208, 32'hFFFF_FFFC);
    pcsource = 2'b00;
    tick(); chk_ifid("jr.top", memw(32'hFFFF_FFFC), 1'b1, 32'h0, 32'h0);
    tick(); chk_ifid("jr.wrap", memw(32'h0), 1'b1, 32'h4, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
